exception_sequencer: RTL and testbench

- Sequences exception entry and return around the main decoder for the LEGv8 single-issue core.
- Synchronises and latches the external interrupt line.
- Arbitrates between the interrupt and an invalid-opcode report from the decoder.
- Captures the return PC (ELR) and status (ESR), then drives PC redirect/flush for vector entry and ERET return; double faults stop the core in a halt state.

---
 rtl/exception_sequencer.sv | 119 +++++++++++
 tb/tb_exception_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exception_sequencer.sv
// Exception entry/return sequencer for the LEGv8 core: synchronises the external IRQ,
// arbitrates it against invalid opcodes, captures ELR/ESR and drives fetch redirect/flush.
module exception_sequencer #(
  parameter int unsigned          PC_WIDTH    = 64,
  parameter logic [PC_WIDTH-1:0]  VECTOR_ADDR = 64'h0000_0000_0000_00D8,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter int unsigned          CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ext_irq,
  input  logic                 instr_valid,
  input  logic                 not_an_instr,
  input  logic                 eret,
  input  logic [PC_WIDTH-1:0]  pc_in,
  output logic                 pc_redirect,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic                 flush,
  output logic                 exc_taken,
  output logic                 in_handler,
  output logic [PC_WIDTH-1:0]  elr,
  output logic [3:0]           esr,
  output logic                 irq_pending,
  output logic                 irq_overrun,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] exc_count
);

  typedef enum logic [2:0] {IDLE, ENTRY, HANDLER, RETURN, HALT} state_t;

  state_t                 state, next_state;
  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   irq_sync_d;
  logic                   irq_edge;
  logic                   take_irq;
  logic                   take_inv;

  assign irq_edge = sync_chain[SYNC_STAGES-1] & ~irq_sync_d;
  assign take_irq = (state == IDLE) & irq_pending;
  assign take_inv = (state == IDLE) & instr_valid & not_an_instr & ~take_irq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_chain <= '0;
      irq_sync_d <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], ext_irq};
      irq_sync_d <= sync_chain[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    pc_redirect = 1'b0;
    redirect_pc = '0;
    flush       = 1'b0;
    exc_taken   = 1'b0;
    in_handler  = 1'b0;
    halted      = 1'b0;
    case (state)
      IDLE: begin
        if (take_irq || take_inv) next_state = ENTRY;
      end
      ENTRY: begin
        exc_taken   = 1'b1;
        flush       = 1'b1;
        pc_redirect = 1'b1;
        redirect_pc = VECTOR_ADDR;
        next_state  = HANDLER;
      end
      HANDLER: begin
        in_handler = 1'b1;
        // A faulting instruction inside the handler outranks its own ERET
        if (instr_valid && not_an_instr) next_state = HALT;
        else if (instr_valid && eret)    next_state = RETURN;
      end
      RETURN: begin
        in_handler  = 1'b1;
        flush       = 1'b1;
        pc_redirect = 1'b1;
        redirect_pc = elr;
        next_state  = IDLE;
      end
      HALT: begin
        halted = 1'b1;
        flush  = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_pending <= 1'b0;
      irq_overrun <= 1'b0;
      elr         <= '0;
      esr         <= '0;
      exc_count   <= '0;
    end else begin
      // Servicing wins over a coincident edge: both IRQs merge into this entry
      if (take_irq)      irq_pending <= 1'b0;
      else if (irq_edge) irq_pending <= 1'b1;
      if (irq_edge && irq_pending) irq_overrun <= 1'b1;
      if (take_irq || take_inv) begin
        elr <= pc_in;
        esr <= take_irq ? 4'b0001 : 4'b0010;
        if (exc_count != '1) exc_count <= exc_count + CNT_WIDTH'(1);
      end else if (state == RETURN) begin
        esr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed and randomized bench for exception_sequencer, checked every cycle
// against a behavioural model of exception entry, handler, return and halt.
module tb_exception_sequencer;

  localparam int unsigned S   = 2;
  localparam logic [63:0] VEC = 64'h0000_0000_0000_00D8;
  localparam int          CMAX = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ext_irq = 1'b0;
  logic        instr_valid = 1'b0;
  logic        not_an_instr = 1'b0;
  logic        eret = 1'b0;
  logic [63:0] pc_in = '0;
  logic        pc_redirect, flush, exc_taken, in_handler, irq_pending, irq_overrun, halted;
  logic [63:0] redirect_pc, elr;
  logic [3:0]  esr;
  logic [7:0]  exc_count;

  int checks = 0;
  int failures = 0;

  // Model: which phase of an exception the core is in, plus architectural registers
  bit          m_entry, m_inh, m_ret, m_halt, m_pend, m_ovr;
  logic [63:0] m_elr;
  logic [3:0]  m_esr;
  int          m_count;
  bit          h[S+1];

  exception_sequencer #(
    .PC_WIDTH(64), .VECTOR_ADDR(VEC), .SYNC_STAGES(S), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .ext_irq(ext_irq), .instr_valid(instr_valid),
    .not_an_instr(not_an_instr), .eret(eret), .pc_in(pc_in),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .flush(flush),
    .exc_taken(exc_taken), .in_handler(in_handler), .elr(elr), .esr(esr),
    .irq_pending(irq_pending), .irq_overrun(irq_overrun), .halted(halted),
    .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_entry = 0; m_inh = 0; m_ret = 0; m_halt = 0; m_pend = 0; m_ovr = 0;
    m_elr = '0; m_esr = '0; m_count = 0;
    for (int i = 0; i <= S; i++) h[i] = 0;
  endtask

  task automatic model_step();
    bit edge_now, idle, t_irq, t_inv;
    if (!reset) begin
      model_reset();
    end else begin
      edge_now = h[S-1] && !h[S];
      idle  = !(m_entry || m_inh || m_ret || m_halt);
      t_irq = idle && m_pend;
      t_inv = idle && instr_valid && not_an_instr && !t_irq;
      if (m_entry) begin
        m_entry = 0; m_inh = 1;
      end else if (m_inh) begin
        if (instr_valid && not_an_instr) begin m_inh = 0; m_halt = 1; end
        else if (instr_valid && eret)    begin m_inh = 0; m_ret = 1; end
      end else if (m_ret) begin
        m_ret = 0; m_esr = 4'd0;
      end else if (t_irq || t_inv) begin
        m_entry = 1;
        m_elr   = pc_in;
        m_esr   = t_irq ? 4'd1 : 4'd2;
        if (m_count < CMAX) m_count++;
      end
      if (edge_now && m_pend) m_ovr = 1;
      if (t_irq) m_pend = 0;
      else if (edge_now) m_pend = 1;
      for (int i = S; i > 0; i--) h[i] = h[i-1];
      h[0] = ext_irq;
    end
  endtask

  task automatic check_all();
    chk("exc_taken",   exc_taken,   m_entry);
    chk("pc_redirect", pc_redirect, m_entry || m_ret);
    chk("redirect_pc", redirect_pc, m_entry ? VEC : (m_ret ? m_elr : 64'd0));
    chk("flush",       flush,       m_entry || m_ret || m_halt);
    chk("in_handler",  in_handler,  m_inh || m_ret);
    chk("halted",      halted,      m_halt);
    chk("elr",         elr,         m_elr);
    chk("esr",         esr,         m_esr);
    chk("irq_pending", irq_pending, m_pend);
    chk("irq_overrun", irq_overrun, m_ovr);
    chk("exc_count",   exc_count,   m_count);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
  endtask

  initial begin
    // Reset held with active inputs, then released quietly
    reset = 0; ext_irq = 1; instr_valid = 1; not_an_instr = 1;
    #2;
    model_reset();
    check_all();
    tick(); tick();
    chk("t1_flush", flush, 0);
    ext_irq = 0; instr_valid = 0; not_an_instr = 0; reset = 1;
    tick(); tick();
    chk("t1_redirect", pc_redirect, 0);

    // Invalid opcode entry and return
    pc_in = 64'h40; instr_valid = 1; not_an_instr = 1;
    tick();
    chk("t2_taken", exc_taken, 1);
    chk("t2_vec", redirect_pc, 64'hD8);
    chk("t2_elr", elr, 64'h40);
    chk("t2_esr", esr, 4'b0010);
    chk("t2_cnt", exc_count, 1);
    instr_valid = 0; not_an_instr = 0;
    tick();
    chk("t2_inh", in_handler, 1);
    instr_valid = 1; eret = 1;
    tick();
    instr_valid = 0; eret = 0;
    tick();

    // IRQ latency and ERET round trip
    ext_irq = 1; pc_in = 64'h100;
    tick(); tick();
    chk("t3_pend_early", irq_pending, 0);
    tick();
    chk("t3_pend", irq_pending, 1);
    tick();
    chk("t3_taken", exc_taken, 1);
    chk("t3_esr", esr, 4'b0001);
    chk("t3_elr", elr, 64'h100);
    tick();
    instr_valid = 1; eret = 1;
    tick();
    chk("t3_ret_pc", redirect_pc, 64'h100);
    chk("t3_ret_flush", flush, 1);
    instr_valid = 0; eret = 0;
    tick();
    chk("t3_esr_clr", esr, 0);
    ext_irq = 0;
    repeat (3) tick();

    // IRQ and invalid op together: IRQ wins, invalid op dropped
    ext_irq = 1;
    repeat (3) tick();
    chk("t4_pend", irq_pending, 1);
    instr_valid = 1; not_an_instr = 1; pc_in = 64'h200;
    tick();
    chk("t4_esr", esr, 4'b0001);
    chk("t4_pend_clr", irq_pending, 0);
    chk("t4_elr", elr, 64'h200);
    instr_valid = 0; not_an_instr = 0;
    tick();
    instr_valid = 1; eret = 1;
    tick();
    instr_valid = 0; eret = 0;
    tick();
    chk("t4_no_reentry", exc_taken, 0);
    ext_irq = 0;
    repeat (3) tick();

    // Masking in handler, overrun, deferred entry after return
    pc_in = 64'h300; instr_valid = 1; not_an_instr = 1;
    tick();
    instr_valid = 0; not_an_instr = 0;
    tick();
    ext_irq = 1;
    repeat (3) tick();
    chk("t5_pend", irq_pending, 1);
    chk("t5_masked", exc_taken, 0);
    ext_irq = 0;
    repeat (2) tick();
    ext_irq = 1;
    repeat (3) tick();
    chk("t5_ovr", irq_overrun, 1);
    pc_in = 64'h380; instr_valid = 1; eret = 1;
    tick();
    chk("t5_ret_pc", redirect_pc, 64'h300);
    instr_valid = 0; eret = 0;
    tick();
    chk("t5_idle", exc_taken, 0);
    tick();
    chk("t5_taken", exc_taken, 1);
    chk("t5_esr", esr, 4'b0001);
    chk("t5_cnt", exc_count, 5);
    tick();
    instr_valid = 1; eret = 1;
    tick();
    instr_valid = 0; eret = 0;
    ext_irq = 0;
    repeat (3) tick();

    // Double fault, async reset out of halt, counter saturation
    pc_in = 64'h400; instr_valid = 1; not_an_instr = 1;
    tick();
    instr_valid = 0; not_an_instr = 0;
    tick();
    pc_in = 64'h480; instr_valid = 1; not_an_instr = 1; eret = 1;
    tick();
    chk("t6_halt", halted, 1);
    chk("t6_elr", elr, 64'h400);
    instr_valid = 0; not_an_instr = 0; eret = 0;
    repeat (3) tick();
    chk("t6_stuck", halted, 1);
    async_reset();
    chk("t6_unhalt", halted, 0);
    tick();
    reset = 1;
    for (int n = 0; n < 300; n++) begin
      pc_in = {$urandom, $urandom}; instr_valid = 1; not_an_instr = 1;
      tick();
      instr_valid = 0; not_an_instr = 0;
      tick();
      instr_valid = 1; eret = 1;
      tick();
      instr_valid = 0; eret = 0;
      tick();
    end
    chk("t6_sat", exc_count, 255);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) ext_irq = ~ext_irq;
      instr_valid  = 1'($urandom_range(0, 1));
      not_an_instr = ($urandom_range(0, 19) == 0);
      eret         = ($urandom_range(0, 3) == 0);
      pc_in        = {$urandom, $urandom};
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
        tick();
        reset = 1;
      end else begin
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
